morse_compose: RTL and testbench
================================

# morse_compose

Receive-side counterpart of the Morse audio path. It samples a single Morse key and measures press and release durations. Each press is classified as short or long, and each completed character is packed into the same 10-bit Morse word the processor writes to `descompose`. The word is held on an output register with a valid/ack handshake so the microcontroller can read characters keyed by the user.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: stable cycles required before a key change is accepted.
- `DOT_MAX_CYCLES`, default 6000000: a press lasting this many cycles or fewer is short; a longer press is long.
- `GAP_CYCLES`, default 12000000: release duration that ends a character.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `key`  in  1  raw key, 1 = pressed, asynchronous to `clk`.
- `ack`  in  1  one-cycle pulse from the consumer; clears `valid`.
- `code`  out  10  last completed character.
- `valid`  out  1  `code` holds an unread character.
- `overflow`  out  1  the last character had more than 5 symbols; latched together with `code`.
- `overrun`  out  1  sticky; a character was loaded while `valid` was already 1. Cleared only by reset.
- `busy`  out  1  a character is in progress (FSM not in IDLE).

## Operation
- Word format: 5 two-bit symbol slots. Slot 0 is `[9:8]`, slot 4 is `[1:0]`. Encodings: 00 = none/terminator, 01 = short, 10 = long. Symbols fill slots from slot 0 upward, and unused slots are 00. The value 11 is never produced.
- Input conditioning: `key` passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- FSM states and transitions:
  - IDLE: shift register and symbol count are 0. A debounced rise moves to PRESS and clears the duration counter.
  - PRESS: the counter increments each cycle and saturates at `DOT_MAX_CYCLES+1`. On a debounced fall, the FSM classifies the press (counter ≤ `DOT_MAX_CYCLES` gives 01, otherwise 10), appends it to the next slot, clears the counter, and moves to GAP. If 5 symbols are already stored, the symbol is dropped and the internal overflow bit is set.
  - GAP: the counter increments each cycle. A debounced rise returns to PRESS with the counter cleared. When the counter reaches `GAP_CYCLES`, the FSM loads `code` and `overflow` from the shift register, sets `valid`, clears the shift register, count, and internal overflow bit, and moves to IDLE.
- Handshake:
  - `valid` falls on the cycle after `ack` is sampled high.
  - If a load and `ack` occur in the same cycle, the load wins: `valid` stays 1 and `code` holds the new word.
  - A load while `valid`=1 without a same-cycle `ack` overwrites `code` and sets `overrun`.
  - `ack` while `valid`=0 is ignored.
- Counter width is `$clog2(max(GAP_CYCLES, DOT_MAX_CYCLES+1)+1)`. Counters never wrap.

## Timing
- Reset values: `code`=0, `valid`=0, `overflow`=0, `overrun`=0, `busy`=0. FSM returns to IDLE, counters are 0, and the debounced level is 0.
- Reset mid-character discards the partial character. A key still held when reset is released is seen as a fresh rise once debounced.
- Raw key edge to debounced edge: 2 + `DEBOUNCE_CYCLES` cycles.
- `valid` rises exactly `GAP_CYCLES` cycles after the debounced fall of the final symbol. `code` is stable from that cycle onward.
- `busy` rises on the cycle after the debounced rise and falls in the same cycle `valid` rises.
- Glitches shorter than `DEBOUNCE_CYCLES` never reach the FSM.

## Structure
- Package `morse_pkg` holds:
  - `SYM_NONE`=2'b00, `SYM_SHORT`=2'b01, `SYM_LONG`=2'b10;
  - `MAX_SYMBOLS`=5;
  - the FSM state enum {IDLE, PRESS, GAP}.
- Sub-module `key_debounce` contains the synchronizer and debounce counter. Its parameter is `DEBOUNCE_CYCLES`; its ports are clk, reset, raw, level.
- The top level contains the FSM, duration counter, shift register and output/handshake registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `DOT_MAX_CYCLES`=20, `GAP_CYCLES`=40.

- **Short + long.** Press 10, release 15, press 30, release ≥50 → `code`=10'b01_10_00_00_00, `valid`=1 exactly 40 cycles after the last debounced fall, `overflow`=0.
- **Boundary classification.** A debounced press of exactly 20 cycles gives 01; exactly 21 cycles gives 10. A release of exactly 39 cycles continues the same character; exactly 40 ends it.
- **Overflow.** 6 short presses with 10-cycle gaps → `code`=10'b01_01_01_01_01, `overflow`=1. The next single-short character gives `code`=10'b01_00_00_00_00, `overflow`=0.
- **Handshake.**
  - No `ack` between two characters → second word replaces the first and `overrun`=1.
  - `ack` coincident with a load → `valid` stays 1.
  - `ack` alone → `valid`=0 on the next cycle.
- **Glitch.** A 3-cycle key pulse → `busy` stays 0 and no character is produced.
- **Reset mid-character.** Reset asserted during GAP after 2 symbols → all outputs 0 immediately. The next character decodes cleanly with no stale symbols.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared symbol encodings, word geometry and FSM state type for the Morse receive path.
package morse_pkg;

    localparam logic [1:0] SYM_NONE  = 2'b00;
    localparam logic [1:0] SYM_SHORT = 2'b01;
    localparam logic [1:0] SYM_LONG  = 2'b10;

    localparam int unsigned MAX_SYMBOLS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Write one symbol into slot idx; slot 0 is word[9:8], slot 4 is word[1:0].
    function automatic logic [9:0] slot_put(input logic [9:0] word,
                                            input logic [2:0] idx,
                                            input logic [1:0] sym);
        logic [9:0] w;
        w = word;
        for (int unsigned i = 0; i < MAX_SYMBOLS; i++) begin
            if (32'(idx) == i) begin
                w[9 - 2 * i -: 2] = sym;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/morse_compose_key_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output level only follows the
// synchronized key after it has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned DCW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     sync_q;
    logic [1:0]     sync_d;
    logic           level_q;
    logic           level_d;
    logic [DCW-1:0] cnt_q;
    logic [DCW-1:0] cnt_d;

    // Next-state: shift the synchronizer, count disagreement, flip level when it has lasted long enough.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DCW'(1);
            end
        end
    end

    // State registers with asynchronous reset to a released key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/morse_compose.sv
// Morse receiver: times debounced key presses/releases, classifies symbols, packs a
// 10-bit word and presents it on a valid/ack output register.
module morse_compose
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DOT_MAX_CYCLES  = 6000000,
    parameter int unsigned GAP_CYCLES      = 12000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    input  logic       ack,
    output logic [9:0] code,
    output logic       valid,
    output logic       overflow,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > DOT_MAX_CYCLES + 1) ? GAP_CYCLES
                                                                        : DOT_MAX_CYCLES + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DOT_MAX   = CNT_W'(DOT_MAX_CYCLES);
    localparam logic [CNT_W-1:0] PRESS_SAT = CNT_W'(DOT_MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic level;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [2:0]       nsym_q, nsym_d;
    logic             ovf_q, ovf_d;
    logic [9:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             load;
    logic [1:0]       sym;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (key),
        .level(level)
    );

    // FSM next-state, duration counting, symbol packing and output handshake.
    // The counter is entered at 1 because the transition cycle is itself the first
    // cycle of the new press/release; this makes the stored count equal the debounced
    // duration and puts the load exactly GAP_CYCLES after the debounced fall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        nsym_d     = nsym_q;
        ovf_d      = ovf_q;
        code_d     = code_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        load       = 1'b0;
        sym        = SYM_NONE;

        case (state_q)
            IDLE: begin
                shift_d = '0;
                nsym_d  = '0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
                if (level) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS: begin
                if (!level) begin
                    sym = (cnt_q <= DOT_MAX) ? SYM_SHORT : SYM_LONG;
                    if (nsym_q < 3'(MAX_SYMBOLS)) begin
                        shift_d = slot_put(shift_q, nsym_q, sym);
                        nsym_d  = nsym_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    cnt_d   = CNT_ONE;
                    state_d = GAP;
                end else if (cnt_q != PRESS_SAT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (level) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == GAP_LAST) begin
                    load    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                    nsym_d  = '0;
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
                nsym_d  = '0;
                ovf_d   = 1'b0;
            end
        endcase

        if (load) begin
            code_d     = shift_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            if (valid_q && !ack) begin
                overrun_d = 1'b1;
            end
        end else if (ack) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // Registered FSM state, datapath and outputs with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            nsym_q     <= '0;
            ovf_q      <= 1'b0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            nsym_q     <= nsym_d;
            ovf_q      <= ovf_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_morse_compose.sv
// Directed bench for morse_compose with DEBOUNCE=4, DOT_MAX=20, GAP=40.
// Key edges are driven 1 time unit after a clock edge; the debounced edge follows
// 6 clock edges later, so a load is visible 46 edges after the raw release.
module tb_morse_compose;

    logic       clk;
    logic       reset;
    logic       key;
    logic       ack;
    logic [9:0] code;
    logic       valid;
    logic       overflow;
    logic       overrun;
    logic       busy;

    int checks;
    int errors;

    morse_compose #(
        .DEBOUNCE_CYCLES(4),
        .DOT_MAX_CYCLES (20),
        .GAP_CYCLES     (40)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key     (key),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .overflow(overflow),
        .overrun (overrun),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        key = 1'b1;
        tick(n);
        key = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key   = 1'b0;
        ack   = 1'b0;
        tick(2);
        checks++; if (code !== 10'b0)   begin $display("FAIL rst_code got %b exp %b", code, 10'b0); errors++; end
        checks++; if (valid !== 1'b0)   begin $display("FAIL rst_valid got %b exp 0", valid); errors++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL rst_overflow got %b exp 0", overflow); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL rst_overrun got %b exp 0", overrun); errors++; end
        checks++; if (busy !== 1'b0)    begin $display("FAIL rst_busy got %b exp 0", busy); errors++; end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_short_long();
        press(10);
        tick(15);
        press(30);
        tick(45);
        checks++; if (valid !== 1'b0) begin $display("FAIL sl_valid_early got %b exp 0", valid); errors++; end
        checks++; if (busy !== 1'b1)  begin $display("FAIL sl_busy_gap got %b exp 1", busy); errors++; end
        tick(1);
        checks++; if (valid !== 1'b1) begin $display("FAIL sl_valid got %b exp 1", valid); errors++; end
        checks++; if (code !== 10'b0110000000) begin $display("FAIL sl_code got %b exp %b", code, 10'b0110000000); errors++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL sl_overflow got %b exp 0", overflow); errors++; end
        checks++; if (busy !== 1'b0)  begin $display("FAIL sl_busy_end got %b exp 0", busy); errors++; end
        pulse_ack();
        checks++; if (valid !== 1'b0) begin $display("FAIL sl_ack got %b exp 0", valid); errors++; end
        tick(5);
    endtask

    task automatic test_boundary();
        press(20);
        tick(39);
        press(21);
        checks++; if (valid !== 1'b0) begin $display("FAIL bd_gap39_novalid got %b exp 0", valid); errors++; end
        tick(40);
        key = 1'b1;
        tick(6);
        checks++; if (valid !== 1'b1) begin $display("FAIL bd_gap40_valid got %b exp 1", valid); errors++; end
        checks++; if (code !== 10'b0110000000) begin $display("FAIL bd_code got %b exp %b", code, 10'b0110000000); errors++; end
        pulse_ack();
        tick(3);
        key = 1'b0;
        tick(46);
        checks++; if (valid !== 1'b1) begin $display("FAIL bd_next_valid got %b exp 1", valid); errors++; end
        checks++; if (code !== 10'b0100000000) begin $display("FAIL bd_next_code got %b exp %b", code, 10'b0100000000); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL bd_overrun got %b exp 0", overrun); errors++; end
        pulse_ack();
        tick(5);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            press(5);
            if (i < 5) tick(10);
        end
        tick(46);
        checks++; if (valid !== 1'b1) begin $display("FAIL of_valid got %b exp 1", valid); errors++; end
        checks++; if (code !== 10'b0101010101) begin $display("FAIL of_code got %b exp %b", code, 10'b0101010101); errors++; end
        checks++; if (overflow !== 1'b1) begin $display("FAIL of_overflow got %b exp 1", overflow); errors++; end
        pulse_ack();
        press(5);
        tick(46);
        checks++; if (code !== 10'b0100000000) begin $display("FAIL of_next_code got %b exp %b", code, 10'b0100000000); errors++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL of_next_overflow got %b exp 0", overflow); errors++; end
        pulse_ack();
        tick(5);
    endtask

    task automatic test_handshake();
        press(5);
        tick(46);
        checks++; if (valid !== 1'b1) begin $display("FAIL hs_a_valid got %b exp 1", valid); errors++; end
        press(25);
        tick(45);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b1) begin $display("FAIL hs_coinc_valid got %b exp 1", valid); errors++; end
        checks++; if (code !== 10'b1000000000) begin $display("FAIL hs_coinc_code got %b exp %b", code, 10'b1000000000); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL hs_coinc_overrun got %b exp 0", overrun); errors++; end
        press(5);
        tick(46);
        checks++; if (code !== 10'b0100000000) begin $display("FAIL hs_ovr_code got %b exp %b", code, 10'b0100000000); errors++; end
        checks++; if (overrun !== 1'b1) begin $display("FAIL hs_ovr_overrun got %b exp 1", overrun); errors++; end
        pulse_ack();
        checks++; if (valid !== 1'b0) begin $display("FAIL hs_ack_valid got %b exp 0", valid); errors++; end
        pulse_ack();
        tick(1);
        checks++; if (valid !== 1'b0) begin $display("FAIL hs_idle_ack_valid got %b exp 0", valid); errors++; end
        checks++; if (overrun !== 1'b1) begin $display("FAIL hs_sticky_overrun got %b exp 1", overrun); errors++; end
        tick(5);
    endtask

    task automatic test_glitch();
        int busy_seen;
        busy_seen = 0;
        press(3);
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (busy === 1'b1) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin $display("FAIL gl_busy got %0d busy cycles exp 0", busy_seen); errors++; end
        checks++; if (valid !== 1'b0) begin $display("FAIL gl_valid got %b exp 0", valid); errors++; end
    endtask

    task automatic test_reset_mid();
        press(5);
        tick(10);
        press(5);
        tick(20);
        checks++; if (busy !== 1'b1) begin $display("FAIL rm_busy_pre got %b exp 1", busy); errors++; end
        reset = 1'b1;
        #1;
        checks++; if (code !== 10'b0)    begin $display("FAIL rm_code got %b exp %b", code, 10'b0); errors++; end
        checks++; if (valid !== 1'b0)    begin $display("FAIL rm_valid got %b exp 0", valid); errors++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL rm_overflow got %b exp 0", overflow); errors++; end
        checks++; if (overrun !== 1'b0)  begin $display("FAIL rm_overrun got %b exp 0", overrun); errors++; end
        checks++; if (busy !== 1'b0)     begin $display("FAIL rm_busy got %b exp 0", busy); errors++; end
        tick(2);
        reset = 1'b0;
        tick(2);
        press(25);
        tick(46);
        checks++; if (valid !== 1'b1) begin $display("FAIL rm_next_valid got %b exp 1", valid); errors++; end
        checks++; if (code !== 10'b1000000000) begin $display("FAIL rm_next_code got %b exp %b", code, 10'b1000000000); errors++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL rm_next_overflow got %b exp 0", overflow); errors++; end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_short_long();
        test_boundary();
        test_overflow();
        test_handshake();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
